// File: rtl/temp_fan_regulator_if.sv
// temp_fan_regulator_if
//   Bundles the sensor-side inputs and the regulator outputs of
//   temp_fan_regulator.
//   slave  : regulator side. temp_in/hum_in come in; the drive and status
//            signals go out.
//   master : sensor / top-level side, with the opposite directions.
//   Signals:
//     temp_in      [7:0] integer temperature from the DHT11 wrapper, degC
//     hum_in       [7:0] integer humidity from the DHT11 wrapper, %RH
//     pwm_out            fan/pump PWM drive
//     fan_level    [1:0] 0=OFF, 1=LOW, 2=HIGH, 3=FAULT
//     fault              high while in FAULT
//     temp_latched [7:0] last valid sampled temperature
//     sample_tick        one-cycle pulse at each sample instant
interface temp_fan_regulator_if;
  logic [7:0] temp_in;
  logic [7:0] hum_in;
  logic       pwm_out;
  logic [1:0] fan_level;
  logic       fault;
  logic [7:0] temp_latched;
  logic       sample_tick;

  modport master (
    output temp_in, hum_in,
    input  pwm_out, fan_level, fault, temp_latched, sample_tick
  );

  modport slave (
    input  temp_in, hum_in,
    output pwm_out, fan_level, fault, temp_latched, sample_tick
  );
endinterface

// File: rtl/temp_fan_regulator.sv
// temp_fan_regulator
//   Samples the DHT11 wrapper's temperature and humidity bytes on a fixed
//   period and rejects implausible readings. A hysteresis state machine
//   (OFF/LOW/HIGH/FAULT) picks the fan drive level, and a PWM generator
//   turns that level into pwm_out. A new duty is only adopted at PWM period
//   boundaries.
//   Ports:
//     clk    system clock
//     rst_n  asynchronous active-low reset
//     bus    temp_fan_regulator_if.slave (temp_in, hum_in in; pwm_out,
//            fan_level, fault, temp_latched, sample_tick out)
module temp_fan_regulator #(
  parameter int unsigned SAMPLE_CYCLES = 50000000,
  parameter int unsigned T_LOW_ON      = 26,
  parameter int unsigned T_HIGH_ON     = 30,
  parameter int unsigned HYST          = 2,
  parameter int unsigned DUTY_LOW      = 128,
  parameter int unsigned PWM_DIV       = 196,
  parameter int unsigned FAULT_LIMIT   = 3,
  parameter int unsigned TEMP_MAX      = 50
) (
  input logic            clk,
  input logic            rst_n,
  temp_fan_regulator_if.slave bus
);

  localparam int SW = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
  localparam int PW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int FW = $clog2(FAULT_LIMIT + 1);

  localparam logic [SW-1:0] SAMPLE_LAST  = SW'(SAMPLE_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_LAST   = PW'(PWM_DIV - 1);
  localparam logic [FW-1:0] FAULT_LIM_B  = FW'(FAULT_LIMIT);
  localparam logic [7:0]    T_LOW_ON_B   = 8'(T_LOW_ON);
  localparam logic [7:0]    T_HIGH_ON_B  = 8'(T_HIGH_ON);
  localparam logic [7:0]    T_LOW_OFF_B  = 8'(T_LOW_ON - HYST);
  localparam logic [7:0]    T_HIGH_OFF_B = 8'(T_HIGH_ON - HYST);
  localparam logic [7:0]    DUTY_LOW_B   = 8'(DUTY_LOW);
  localparam logic [7:0]    TEMP_MAX_B   = 8'(TEMP_MAX);

  // The OFF thresholds are built by subtraction and must stay non-negative.
  if ((HYST > T_LOW_ON) || (HYST > T_HIGH_ON) || (T_HIGH_ON > 255) ||
      (SAMPLE_CYCLES < 1) || (PWM_DIV < 1) || (FAULT_LIMIT < 1)) begin : g_param_check
    $error("temp_fan_regulator: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_LOW   = 2'd1,
    ST_HIGH  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  // Hysteresis rules for a valid temperature; FAULT recovers through the OFF rules.
  function automatic state_t rule_next(input state_t cur, input logic [7:0] t);
    state_t nxt;
    nxt = cur;
    case (cur)
      ST_LOW: begin
        if (t >= T_HIGH_ON_B)      nxt = ST_HIGH;
        else if (t <= T_LOW_OFF_B) nxt = ST_OFF;
        else                       nxt = ST_LOW;
      end
      ST_HIGH: begin
        if (t <= T_LOW_OFF_B)       nxt = ST_OFF;
        else if (t <= T_HIGH_OFF_B) nxt = ST_LOW;
        else                        nxt = ST_HIGH;
      end
      ST_OFF, ST_FAULT: begin
        if (t >= T_HIGH_ON_B)     nxt = ST_HIGH;
        else if (t >= T_LOW_ON_B) nxt = ST_LOW;
        else                      nxt = ST_OFF;
      end
      default: nxt = ST_FAULT;
    endcase
    return nxt;
  endfunction

  logic [SW-1:0] sample_cnt_r;
  logic          sample_tick_r;
  logic [FW-1:0] inv_cnt_r;
  state_t        state_r;
  logic          fault_r;
  logic [7:0]    temp_latched_r;
  logic [PW-1:0] presc_r;
  logic [7:0]    pwm_cnt_r;
  logic [7:0]    duty_active_r;
  logic          pwm_out_r;

  logic          tick_s;
  logic          valid_s;
  logic [FW-1:0] inv_inc_s;
  state_t        valid_next_s;
  logic          presc_wrap_s;
  logic [7:0]    target_duty_s;

  // Sample decision, plausibility check and saturating invalid count.
  always_comb begin
    tick_s       = (sample_cnt_r == SAMPLE_LAST);
    valid_s      = !((bus.temp_in > TEMP_MAX_B) || (bus.hum_in > 8'd100) ||
                     ((bus.temp_in == 8'd0) && (bus.hum_in == 8'd0)));
    valid_next_s = rule_next(state_r, bus.temp_in);
    if (inv_cnt_r == FAULT_LIM_B) begin
      inv_inc_s = inv_cnt_r;
    end else begin
      inv_inc_s = inv_cnt_r + FW'(1);
    end
  end

  // Target duty per level; FAULT drives fully as the fail-safe.
  always_comb begin
    presc_wrap_s = (presc_r == PRESC_LAST);
    case (state_r)
      ST_OFF:   target_duty_s = 8'd0;
      ST_LOW:   target_duty_s = DUTY_LOW_B;
      ST_HIGH:  target_duty_s = 8'd255;
      ST_FAULT: target_duty_s = 8'd255;
      default:  target_duty_s = 8'd255;
    endcase
  end

  // Sample timer: sample_tick_r marks the cycle after the counter's last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt_r  <= '0;
      sample_tick_r <= 1'b0;
    end else begin
      sample_tick_r <= tick_s;
      sample_cnt_r  <= tick_s ? '0 : sample_cnt_r + SW'(1);
    end
  end

  // Regulation FSM; an invalid sample holds everything unless it completes the fault run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= ST_OFF;
      fault_r        <= 1'b0;
      inv_cnt_r      <= '0;
      temp_latched_r <= 8'd0;
    end else if (tick_s) begin
      if (valid_s) begin
        inv_cnt_r      <= '0;
        temp_latched_r <= bus.temp_in;
        state_r        <= valid_next_s;
        fault_r        <= 1'b0;
      end else begin
        inv_cnt_r <= inv_inc_s;
        if (inv_inc_s == FAULT_LIM_B) begin
          state_r <= ST_FAULT;
          fault_r <= 1'b1;
        end
      end
    end
  end

  // PWM: duty is reloaded only when a period ends, so periods are never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r       <= '0;
      pwm_cnt_r     <= 8'd0;
      duty_active_r <= 8'd0;
      pwm_out_r     <= 1'b0;
    end else begin
      pwm_out_r <= (duty_active_r == 8'd255) || (pwm_cnt_r < duty_active_r);
      if (presc_wrap_s) begin
        presc_r   <= '0;
        pwm_cnt_r <= pwm_cnt_r + 8'd1;
        if (pwm_cnt_r == 8'd255) begin
          duty_active_r <= target_duty_s;
        end
      end else begin
        presc_r <= presc_r + PW'(1);
      end
    end
  end

  assign bus.pwm_out      = pwm_out_r;
  assign bus.fan_level    = state_r;
  assign bus.fault        = fault_r;
  assign bus.temp_latched = temp_latched_r;
  assign bus.sample_tick  = sample_tick_r;

endmodule

// File: tb/tb_temp_fan_regulator.sv
// tb_temp_fan_regulator
//   Directed stimulus for temp_fan_regulator with SAMPLE_CYCLES=16 and
//   PWM_DIV=1. Each directed sample pushes its expected {fan_level, fault,
//   temp_latched} into a queue. A monitor pops and compares the queue on
//   every sample_tick. Ticks with no new expectation are compared against
//   the previous expectation, because the inputs are held steady. PWM duty,
//   reset behaviour and tick timing are checked inline.
module tb_temp_fan_regulator;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [10:0] exp_q[$];
  logic [10:0] last_exp;
  logic [10:0] mon_exp;
  logic [10:0] mon_got;

  temp_fan_regulator_if bus();

  temp_fan_regulator #(
    .SAMPLE_CYCLES(16),
    .PWM_DIV(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare the regulator status at every sample tick.
  always @(negedge clk) begin
    if (rst_n && bus.sample_tick) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else mon_exp = last_exp;
      last_exp = mon_exp;
      mon_got = {bus.fan_level, bus.fault, bus.temp_latched};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL tick_status: got lvl=%0d fault=%0d temp=%0d, want lvl=%0d fault=%0d temp=%0d",
                 mon_got[10:9], mon_got[8], mon_got[7:0], mon_exp[10:9], mon_exp[8], mon_exp[7:0]);
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Wait (bounded) for the next sample tick; n = negedges waited.
  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sample_tick && n < 40);
    if (!bus.sample_tick) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: no sample_tick within %0d cycles", n);
    end
    #1;
  endtask

  task automatic apply(input logic [7:0] t, input logic [7:0] h,
                       input logic [1:0] lvl, input logic flt, input logic [7:0] tl);
    int n;
    bus.temp_in = t;
    bus.hum_in  = h;
    exp_q.push_back({lvl, flt, tl});
    wait_tick(n);
  endtask

  // Let the duty settle past a boundary, count high cycles over one full period, then resync to a tick.
  task automatic pwm_window(input string name, input int want);
    int cnt;
    int n;
    repeat (512) @(negedge clk);
    cnt = 0;
    repeat (256) begin
      @(negedge clk);
      if (bus.pwm_out) cnt++;
    end
    check(name, cnt, want);
    wait_tick(n);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    errors = 0;
    checks = 0;
    last_exp = 11'd0;
    rst_n = 1'b0;
    bus.temp_in = 8'd0;
    bus.hum_in  = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", int'(bus.pwm_out), 0);
    check("rst_fan_level", int'(bus.fan_level), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_temp_latched", int'(bus.temp_latched), 0);
    check("rst_sample_tick", int'(bus.sample_tick), 0);

    // Unread sensor (0/0): three invalid samples lead to FAULT, full drive.
    exp_q.push_back({2'd0, 1'b0, 8'd0});
    rst_n = 1'b1;
    wait_tick(n);
    check("first_tick_latency", n, 16);
    apply(8'd0, 8'd0, 2'd0, 1'b0, 8'd0);
    apply(8'd0, 8'd0, 2'd3, 1'b1, 8'd0);
    pwm_window("pwm_fault_highs", 256);

    // FAULT recovers with 27 degC through the OFF rules, giving LOW at half duty.
    apply(8'd27, 8'd40, 2'd1, 1'b0, 8'd27);
    pwm_window("pwm_low_highs", 128);

    // Hysteresis walk.
    apply(8'd31, 8'd40, 2'd2, 1'b0, 8'd31);
    apply(8'd29, 8'd40, 2'd2, 1'b0, 8'd29);
    apply(8'd28, 8'd40, 2'd1, 1'b0, 8'd28);
    apply(8'd25, 8'd40, 2'd1, 1'b0, 8'd25);
    apply(8'd24, 8'd40, 2'd0, 1'b0, 8'd24);
    pwm_window("pwm_off_highs", 0);

    // OFF straight to HIGH; two invalid samples hold; a valid sample clears the count.
    apply(8'd35, 8'd40, 2'd2, 1'b0, 8'd35);
    apply(8'd60, 8'd40, 2'd2, 1'b0, 8'd35);
    apply(8'd60, 8'd40, 2'd2, 1'b0, 8'd35);
    apply(8'd22, 8'd40, 2'd0, 1'b0, 8'd22);
    apply(8'd60, 8'd40, 2'd0, 1'b0, 8'd22);
    apply(8'd60, 8'd40, 2'd0, 1'b0, 8'd22);
    apply(8'd27, 8'd40, 2'd1, 1'b0, 8'd27);

    // Range boundaries: 50 degC and 100 %RH are valid; 51 and 101 are not.
    apply(8'd50, 8'd100, 2'd2, 1'b0, 8'd50);
    apply(8'd51, 8'd10,  2'd2, 1'b0, 8'd50);
    apply(8'd20, 8'd101, 2'd2, 1'b0, 8'd50);
    apply(8'd0,  8'd0,   2'd3, 1'b1, 8'd50);
    apply(8'd28, 8'd50,  2'd1, 1'b0, 8'd28);

    // Reset while the PWM output is high.
    repeat (512) @(negedge clk);
    n = 0;
    while (!bus.pwm_out && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("pwm_high_before_reset", int'(bus.pwm_out), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm_out", int'(bus.pwm_out), 0);
    check("async_rst_fan_level", int'(bus.fan_level), 0);
    check("async_rst_temp_latched", int'(bus.temp_latched), 0);
    last_exp = 11'd0;
    @(negedge clk);
    exp_q.push_back({2'd1, 1'b0, 8'd28});
    rst_n = 1'b1;
    wait_tick(n);
    check("tick_latency_after_reset", n, 16);
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
